// File: rtl/ysyx_22040386_ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040386_ifu_pkg
// Description : Shared constants and FSM state encoding for the NPC fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22040386_ifu_pkg;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
    localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;
    localparam logic [63:0] PC_STEP          = 64'd4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_HALT = 3'd4
    } ifu_state_t;

endpackage
`default_nettype wire

// File: rtl/ysyx_22040386_ifu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040386_ifu
// Description : Single-outstanding instruction fetch unit with redirect/halt.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040386_ifu
    import ysyx_22040386_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        halted,
    output logic        fetch_fault,
    output logic [63:0] inst_cnt
);

    ifu_state_t  r_state;
    logic [63:0] r_pc;
    logic        r_kill;
    logic [31:0] r_inst;
    logic [63:0] r_inst_pc;
    logic        r_fault;
    logic [63:0] r_cnt;

    logic        w_redir_ok;
    logic        w_redir_bad;

    assign w_redir_ok  = redirect_valid & (redirect_pc[1:0] == 2'b00);
    assign w_redir_bad = redirect_valid & (redirect_pc[1:0] != 2'b00);

    // Handshake outputs are pure state decodes, so no input reaches them combinationally.
    assign imem_req_valid = (r_state == ST_REQ);
    assign inst_valid     = (r_state == ST_HOLD);
    assign halted         = (r_state == ST_HALT);
    assign imem_addr      = r_pc;
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;
    assign fetch_fault    = r_fault;
    assign inst_cnt       = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= RESET_PC;
            r_kill    <= 1'b0;
            r_inst    <= 32'd0;
            r_inst_pc <= 64'd0;
            r_fault   <= 1'b0;
            r_cnt     <= 64'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_redir_bad) begin
                        r_fault <= 1'b1;
                        r_state <= ST_HALT;
                    end else begin
                        if (w_redir_ok) begin
                            r_pc <= redirect_pc;
                        end
                        r_state <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (w_redir_bad) begin
                        r_fault <= 1'b1;
                        r_state <= ST_HALT;
                    end else begin
                        if (w_redir_ok) begin
                            r_pc <= redirect_pc;
                        end
                        // An accepted request whose address was just redirected must be dropped.
                        if (imem_req_ready) begin
                            r_kill  <= w_redir_ok;
                            r_state <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (w_redir_bad) begin
                        r_kill  <= 1'b0;
                        r_fault <= 1'b1;
                        r_state <= ST_HALT;
                    end else if (w_redir_ok) begin
                        r_pc <= redirect_pc;
                        // A same-cycle response is the stale one; nothing is left outstanding.
                        if (imem_rsp_valid) begin
                            r_kill  <= 1'b0;
                            r_state <= ST_REQ;
                        end else begin
                            r_kill <= 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        if (r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= ST_REQ;
                        end else begin
                            r_inst    <= imem_rsp_data;
                            r_inst_pc <= r_pc;
                            r_state   <= ST_HOLD;
                        end
                    end
                end

                ST_HOLD: begin
                    if (inst_ready) begin
                        r_cnt <= r_cnt + 64'd1;
                    end
                    if (w_redir_bad) begin
                        r_fault <= 1'b1;
                        r_state <= ST_HALT;
                    end else if (inst_ready && (r_inst == EBREAK_INST)) begin
                        r_state <= ST_HALT;
                    end else if (w_redir_ok) begin
                        r_pc    <= redirect_pc;
                        r_state <= ST_REQ;
                    end else if (inst_ready) begin
                        r_pc    <= r_pc + PC_STEP;
                        r_state <= ST_REQ;
                    end
                end

                ST_HALT: begin
                    r_state <= ST_HALT;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040386_ifu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22040386_ifu
// Description : Directed self-checking bench for the fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040386_ifu;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halted;
    logic        fetch_fault;
    logic [63:0] inst_cnt;

    int n_cmp;
    int n_bad;

    ysyx_22040386_ifu #(
        .RESET_PC (64'h8000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .fetch_fault    (fetch_fault),
        .inst_cnt       (inst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".req_valid"},  {63'd0, imem_req_valid}, 64'd0);
        chk({tag, ".addr"},       imem_addr,               64'h8000_0000);
        chk({tag, ".inst_valid"}, {63'd0, inst_valid},     64'd0);
        chk({tag, ".inst"},       {32'd0, inst},           64'd0);
        chk({tag, ".inst_pc"},    inst_pc,                 64'd0);
        chk({tag, ".halted"},     {63'd0, halted},         64'd0);
        chk({tag, ".fault"},      {63'd0, fetch_fault},    64'd0);
        chk({tag, ".cnt"},        inst_cnt,                64'd0);
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;

        // Reset state, then release
        step();
        chk_reset_outputs("rst");
        rst_n          = 1'b1;
        imem_req_ready = 1'b1;

        // First fetch with zero-wait memory
        step();
        chk("f1.req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("f1.addr", imem_addr, 64'h8000_0000);
        step();
        chk("f1.wait_req", {63'd0, imem_req_valid}, 64'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0413;
        step();
        imem_rsp_valid = 1'b0;
        chk("f1.inst_valid", {63'd0, inst_valid}, 64'd1);
        chk("f1.inst", {32'd0, inst}, 64'h0000_0413);
        chk("f1.inst_pc", inst_pc, 64'h8000_0000);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("f2.req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("f2.addr", imem_addr, 64'h8000_0004);
        chk("f2.cnt", inst_cnt, 64'd1);
        chk("f2.inst_valid", {63'd0, inst_valid}, 64'd0);

        // Decode stalls five cycles in HOLD
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0010_0093;
        step();
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall.inst_valid", {63'd0, inst_valid}, 64'd1);
            chk("stall.inst", {32'd0, inst}, 64'h0010_0093);
            chk("stall.inst_pc", inst_pc, 64'h8000_0004);
            chk("stall.req_valid", {63'd0, imem_req_valid}, 64'd0);
            step();
        end
        chk("stall.cnt_before", inst_cnt, 64'd1);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("stall.cnt_after", inst_cnt, 64'd2);
        chk("stall.next_addr", imem_addr, 64'h8000_0008);
        chk("stall.next_req", {63'd0, imem_req_valid}, 64'd1);

        // Redirect while waiting; stale response arrives three cycles later
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        step();
        redirect_valid = 1'b0;
        chk("kill.w1_valid", {63'd0, inst_valid}, 64'd0);
        chk("kill.w1_req", {63'd0, imem_req_valid}, 64'd0);
        step();
        chk("kill.w2_valid", {63'd0, inst_valid}, 64'd0);
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        chk("kill.inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("kill.req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("kill.addr", imem_addr, 64'h8000_0100);

        // Redirect together with consume in HOLD
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0513;
        step();
        imem_rsp_valid = 1'b0;
        chk("hredir.inst", {32'd0, inst}, 64'h0000_0513);
        chk("hredir.inst_pc", inst_pc, 64'h8000_0100);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        step();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        chk("hredir.cnt", inst_cnt, 64'd3);
        chk("hredir.addr", imem_addr, 64'h8000_0100);
        chk("hredir.req_valid", {63'd0, imem_req_valid}, 64'd1);

        // ebreak consumed -> halt, redirects ignored
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0010_0073;
        step();
        imem_rsp_valid = 1'b0;
        chk("ebrk.inst", {32'd0, inst}, 64'h0010_0073);
        chk("ebrk.halted_pre", {63'd0, halted}, 64'd0);
        inst_ready = 1'b1;
        step();
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0300;
        chk("ebrk.halted", {63'd0, halted}, 64'd1);
        chk("ebrk.cnt", inst_cnt, 64'd4);
        chk("ebrk.inst_valid", {63'd0, inst_valid}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ebrk.no_req", {63'd0, imem_req_valid}, 64'd0);
            chk("ebrk.halted_stay", {63'd0, halted}, 64'd1);
        end
        chk("ebrk.pc_kept", imem_addr, 64'h8000_0100);
        chk("ebrk.no_fault", {63'd0, fetch_fault}, 64'd0);
        redirect_valid = 1'b0;

        // Reset out of HALT, then misaligned redirect in WAIT
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst2");
        step();
        rst_n = 1'b1;
        step();
        chk("mis.req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("mis.addr", imem_addr, 64'h8000_0000);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0102;
        step();
        redirect_valid = 1'b0;
        chk("mis.fault", {63'd0, fetch_fault}, 64'd1);
        chk("mis.halted", {63'd0, halted}, 64'd1);
        chk("mis.pc_kept", imem_addr, 64'h8000_0000);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        step();
        imem_rsp_valid = 1'b0;
        chk("mis.rsp_ignored", {63'd0, inst_valid}, 64'd0);
        chk("mis.no_req", {63'd0, imem_req_valid}, 64'd0);

        // Reset mid-WAIT with a late response around release
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst3");
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("rw.in_wait", {63'd0, imem_req_valid}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst4");
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        rst_n = 1'b1;
        step();
        imem_rsp_valid = 1'b0;
        chk("rw.req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("rw.addr", imem_addr, 64'h8000_0000);
        chk("rw.inst_valid", {63'd0, inst_valid}, 64'd0);

        // Redirect in REQ without accept, then 64-bit PC wrap
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("wrap.req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("wrap.addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        imem_req_ready = 1'b1;
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        step();
        imem_rsp_valid = 1'b0;
        chk("wrap.inst_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("wrap.addr0", imem_addr, 64'd0);
        chk("wrap.cnt", inst_cnt, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_22040386_ifu.md
# ysyx_22040386_ifu

Instruction fetch unit for the NPC core. It owns the program counter and issues one word-aligned fetch at a time to instruction memory. It delivers each returned 32-bit instruction, with its PC, to the decode stage over a valid/ready handshake, and accepts PC redirects from execute for jal/jalr/branches. It stops fetching permanently, until reset, after handing off `ebreak` (32'h0010_0073) or on a misaligned redirect.

## Interface
Parameters:
- `RESET_PC`, 64'h8000_0000, PC loaded on reset.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_addr`  out  64  fetch address, always equal to `pc`.
- `imem_rsp_valid`  in  1  fetch data valid; never earlier than the cycle after acceptance.
- `imem_rsp_data`  in  32  fetched instruction word.
- `inst_valid`  out  1  `inst`/`inst_pc` hold a deliverable instruction.
- `inst_ready`  in  1  decode consumes the instruction this cycle.
- `inst`  out  32  instruction to decode.
- `inst_pc`  out  64  PC of `inst`.
- `redirect_valid`  in  1  execute requests a PC change.
- `redirect_pc`  in  64  new PC.
- `halted`  out  1  fetch stopped (ebreak or fault), sticky.
- `fetch_fault`  out  1  stopped because `redirect_pc[1:0] != 0`, sticky.
- `inst_cnt`  out  64  number of instructions consumed by decode.

## Operation
- State machine states: IDLE, REQ, WAIT, HOLD, HALT. Reset enters IDLE.
- IDLE: all request/valid outputs low. Always moves to REQ on the next edge.
- REQ: `imem_req_valid=1`, `imem_addr=pc`.
  - On `imem_req_ready`, go to WAIT.
- WAIT: wait for `imem_rsp_valid`.
  - If the `kill` flag is set, discard the data, clear `kill`, and go to REQ.
  - Otherwise capture the data into `inst`, capture `pc` into `inst_pc`, and go to HOLD.
- HOLD: `inst_valid=1`; `inst` and `inst_pc` stay stable until consumed.
  - On `inst_ready`, `inst_cnt` increments.
  - If `inst==32'h0010_0073`, go to HALT.
  - Otherwise, with no redirect, `pc<=pc+4` and go to REQ.
- HALT: `halted=1`. No requests are issued; redirects and responses are ignored. It is left only by reset.
- Redirect (`redirect_valid=1` with `redirect_pc[1:0]==0`) has priority over sequential PC update:
  - REQ without accept: `pc<=redirect_pc`, stay in REQ. This is the only case where `imem_addr` may change while `imem_req_valid` is high.
  - REQ with accept the same cycle: go to WAIT, set `kill`, `pc<=redirect_pc`.
  - WAIT: set `kill` and `pc<=redirect_pc`. A response arriving in the same cycle is discarded.
  - HOLD with `inst_ready`: the instruction is consumed and counted, `pc<=redirect_pc`, go to REQ. An `ebreak` still goes to HALT.
  - HOLD without `inst_ready`: the buffered instruction is flushed (`inst_valid` low next cycle), `pc<=redirect_pc`, go to REQ.
  - IDLE: `pc<=redirect_pc`.
- Misaligned redirect (`redirect_pc[1:0]!=0`) in any state except HALT:
  - Set `fetch_fault=1`, go to HALT; `pc` is unchanged.
  - An outstanding response is ignored.
  - In HOLD with `inst_ready`, the instruction is still counted.
- PC arithmetic is 64-bit modulo; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0. `inst_cnt` wraps likewise.
- `imem_rsp_valid` outside WAIT is ignored.

## Timing
- Reset values: `pc=RESET_PC`, `imem_req_valid=0`, `inst_valid=0`, `inst=0`, `inst_pc=0`, `halted=0`, `fetch_fault=0`, `inst_cnt=0`, `kill=0`. State is IDLE.
- First request is asserted in the 2nd cycle after `rst_n` rises.
- With zero-wait memory (ready=1, response 1 cycle after accept), the sequence is REQ, WAIT, HOLD. That gives one instruction per 3 cycles, with `inst_valid` 2 cycles after the request is accepted.
- All outputs are registered or decoded from state only. There is no combinational path from `inst_ready` or `redirect_*` to any output.
- Asserting `rst_n=0` at any point returns all outputs to reset values immediately. A late response after reset is ignored (state is IDLE).

## Structure
- The shared package/header holds `RESET_PC` default, `EBREAK_INST` (32'h0010_0073), and the state encoding; the decoder uses the same `EBREAK_INST` constant.
- Single module, no sub-module. The PC register, kill flag, instruction buffer and counter are all local.

## Test plan
- Reset then zero-wait memory returning 32'h0000_0413 → request at 64'h8000_0000; `inst_valid=1`, `inst_pc=64'h8000_0000`; after handshake the next request goes to 64'h8000_0004 and `inst_cnt=1`.
- `inst_ready` held low 5 cycles in HOLD → `inst`/`inst_pc` stable, `imem_req_valid=0` throughout, then one consume and `inst_cnt` +1.
- Redirect to 64'h8000_0100 during WAIT, response 32'hDEAD_BEEF arrives 3 cycles later → `inst_valid` never rises for it; next request address is 64'h8000_0100.
- Redirect to 64'h8000_0100 with `inst_ready` in HOLD → instruction counted; next request address is 64'h8000_0100, not pc+4.
- Response 32'h0010_0073 consumed → `halted=1` next cycle; no further `imem_req_valid` even with `redirect_valid=1`.
- Redirect to 64'h8000_0102 → `fetch_fault=1`, `halted=1`. Then pull `rst_n` low mid-WAIT → all outputs at reset values that cycle, and the first request after release is at 64'h8000_0000.
